// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a start bit, then shifts
// one command byte plus odd parity out on device clock falls and checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_BITS, S_STOP, S_ACK_WAIT, S_DONE, S_ERR
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       shift_q, shift_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             tx_done_q, tx_done_d;
  logic             tx_err_q, tx_err_d;
  logic             busy_q, busy_d;
  logic             tx_ready_q, tx_ready_d;

  logic [1:0] clk_sync_q, data_sync_q;
  logic       clk_prev_q;
  logic       clk_s, data_s, fall, timed;

  // Idle bus lines are pulled high, so the synchronisers reset to 1 to avoid a false fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign fall   = clk_prev_q & ~clk_s;
  assign timed  = (state_q == S_START) || (state_q == S_BITS) ||
                  (state_q == S_STOP)  || (state_q == S_ACK_WAIT);

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;

    if (timed) begin
      cnt_d = fall ? '0 : cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid && tx_ready_q) begin
          shift_d   = {~^tx_data, tx_data};
          bit_cnt_d = 4'd0;
          cnt_d     = '0;
          clk_oe_d  = 1'b1;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          data_oe_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_START;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_START: begin
        clk_oe_d = 1'b0;
        if (fall) begin
          data_oe_d = ~shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = 4'd1;
          state_d   = S_BITS;
        end
      end
      S_BITS: begin
        if (fall) begin
          if (bit_cnt_q == 4'd9) begin
            data_oe_d = 1'b0;
            state_d   = S_STOP;
          end else begin
            data_oe_d = ~shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      S_STOP: begin
        data_oe_d = 1'b0;
        if (fall) begin
          state_d = data_s ? S_ERR : S_ACK_WAIT;
        end
      end
      S_ACK_WAIT: begin
        if (clk_s && data_s) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_ERR: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A silent device aborts the transfer; a fall in the same cycle restarts the window.
    if (timed && !fall && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      state_d   = S_ERR;
    end

    tx_done_d  = (state_d == S_DONE);
    tx_err_d   = (state_d == S_ERR);
    busy_d     = (state_d != S_IDLE);
    tx_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
      busy_q     <= 1'b0;
      tx_ready_q <= 1'b1;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      tx_done_q  <= tx_done_d;
      tx_err_q   <= tx_err_d;
      busy_q     <= busy_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  assign tx_ready    = tx_ready_q;
  assign tx_done     = tx_done_q;
  assign tx_err      = tx_err_q;
  assign busy        = busy_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: an open-drain bus model and a device BFM that
// clocks the frame, captures start/data/parity/stop and answers with ACK or NACK.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INHIBIT = 40;
  localparam int TIMEOUT = 2000;
  localparam int HALF    = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_done, tx_err, busy;
  logic       ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk, dev_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fall_cyc = 0;

  int   done_total = 0, err_total = 0, inh_total = 0;
  bit   accept_pulse_bad = 1'b0, both_pulse_bad = 1'b0;
  logic ready_at_done = 1'bx, ready_after_done = 1'bx, done_prev = 1'b0;

  ps2_host_tx #(.INHIBIT_CYCLES(INHIBIT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err), .busy(busy),
    .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  // Wired-AND bus: either side may pull a line low.
  assign ps2_clk_i  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done) done_total <= done_total + 1;
    if (tx_err) err_total <= err_total + 1;
    if (ps2_clk_oe && !ps2_data_oe) inh_total <= inh_total + 1;
    if (tx_valid && tx_ready && (tx_done || tx_err)) accept_pulse_bad <= 1'b1;
    if (tx_done && tx_err) both_pulse_bad <= 1'b1;
    if (done_prev) ready_after_done <= tx_ready;
    if (tx_done) ready_at_done <= tx_ready;
    done_prev <= tx_done;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device side: start bit sampled before fall 1, data/parity/stop on rises 1..10,
  // ACK (if requested) driven low through the 11th low phase. Stops early after n_falls.
  task automatic device_xfer(input bit ack, input int n_falls, output logic [10:0] cap);
    int w;
    cap      = '0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    w = 0;
    while (!(ps2_clk_i && !ps2_data_i) && w < 300) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (!(ps2_clk_i && !ps2_data_i)) begin
      errors++;
      $display("FAIL bfm_start_wait: clk=%b data=%b after %0d cycles, required clk=1 data=0",
               ps2_clk_i, ps2_data_i, w);
      return;
    end
    repeat (HALF) @(negedge clk);
    for (int i = 1; i <= n_falls; i++) begin
      if (i == 1) cap[0] = ps2_data_i;
      dev_clk = 1'b0;
      if (i == 11 && ack) dev_data = 1'b0;
      fall_cyc = cyc;
      if (i == n_falls && n_falls < 11) return;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (i <= 10) cap[i] = ps2_data_i;
      if (i == 11) dev_data = 1'b1;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; dev_clk = 1'b1; dev_data = 1'b1;
    #2 rst = 1'b0;
    #3;
    checks++; if (ps2_clk_oe !== 1'b0)  begin errors++; $display("FAIL reset_clk_oe: got %b, required 0", ps2_clk_oe); end
    checks++; if (ps2_data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe: got %b, required 0", ps2_data_oe); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (tx_ready !== 1'b1)    begin errors++; $display("FAIL reset_tx_ready: got %b, required 1", tx_ready); end
    checks++; if (tx_done !== 1'b0)     begin errors++; $display("FAIL reset_tx_done: got %b, required 0", tx_done); end
    checks++; if (tx_err !== 1'b0)      begin errors++; $display("FAIL reset_tx_err: got %b, required 0", tx_err); end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_send_ed;
    logic [10:0] cap;
    int d0, e0, i0;
    d0 = done_total; e0 = err_total; i0 = inh_total;
    send_byte(8'hED);
    device_xfer(1'b1, 11, cap);
    checks++; if (cap !== {1'b1, 1'b1, 8'hED, 1'b0}) begin errors++; $display("FAIL ed_frame: got %b, required %b", cap, {1'b1, 1'b1, 8'hED, 1'b0}); end
    checks++; if (done_total - d0 !== 1) begin errors++; $display("FAIL ed_done_pulses: got %0d, required 1", done_total - d0); end
    checks++; if (err_total - e0 !== 0)  begin errors++; $display("FAIL ed_err_pulses: got %0d, required 0", err_total - e0); end
    checks++; if (inh_total - i0 !== INHIBIT) begin errors++; $display("FAIL ed_inhibit_len: got %0d, required %0d", inh_total - i0, INHIBIT); end
    checks++; if (busy !== 1'b0 || tx_ready !== 1'b1) begin errors++; $display("FAIL ed_idle_after: busy=%b ready=%b, required 0/1", busy, tx_ready); end
  endtask

  task automatic test_parity;
    logic [7:0]  bytes [2] = '{8'h01, 8'hFF};
    logic [10:0] frames[2] = '{{1'b1, 1'b0, 8'h01, 1'b0}, {1'b1, 1'b1, 8'hFF, 1'b0}};
    logic [10:0] cap;
    int d0;
    for (int k = 0; k < 2; k++) begin
      d0 = done_total;
      send_byte(bytes[k]);
      device_xfer(1'b1, 11, cap);
      checks++; if (cap !== frames[k]) begin errors++; $display("FAIL parity_frame_%h: got %b, required %b", bytes[k], cap, frames[k]); end
      checks++; if (done_total - d0 !== 1) begin errors++; $display("FAIL parity_done_%h: got %0d, required 1", bytes[k], done_total - d0); end
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] cap;
    bit saw_ready;
    int d0;
    saw_ready = 1'b0;
    d0 = done_total;
    send_byte(8'hAA);
    fork
      device_xfer(1'b1, 11, cap);
      begin
        repeat (10) @(negedge clk);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        repeat (60) begin
          @(negedge clk);
          if (tx_ready) saw_ready = 1'b1;
        end
        tx_valid = 1'b0;
      end
    join
    checks++; if (saw_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_while_busy: got 1, required 0"); end
    checks++; if (cap !== {1'b1, 1'b1, 8'hAA, 1'b0}) begin errors++; $display("FAIL b2b_first_frame: got %b, required %b", cap, {1'b1, 1'b1, 8'hAA, 1'b0}); end
    checks++; if (done_total - d0 !== 1) begin errors++; $display("FAIL b2b_done_pulses: got %0d, required 1", done_total - d0); end
    checks++; if (ready_at_done !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_done: got %b, required 0", ready_at_done); end
    checks++; if (ready_after_done !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_done: got %b, required 1", ready_after_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_queued: busy=%b, required 0", busy); end
    send_byte(8'hF4);
    device_xfer(1'b1, 11, cap);
    checks++; if (cap !== {1'b1, 1'b0, 8'hF4, 1'b0}) begin errors++; $display("FAIL b2b_f4_frame: got %b, required %b", cap, {1'b1, 1'b0, 8'hF4, 1'b0}); end
  endtask

  task automatic test_nack;
    logic [10:0] cap;
    int d0, e0;
    d0 = done_total; e0 = err_total;
    send_byte(8'h3C);
    device_xfer(1'b0, 11, cap);
    checks++; if (cap !== {1'b1, 1'b1, 8'h3C, 1'b0}) begin errors++; $display("FAIL nack_frame: got %b, required %b", cap, {1'b1, 1'b1, 8'h3C, 1'b0}); end
    checks++; if (err_total - e0 !== 1)  begin errors++; $display("FAIL nack_err_pulses: got %0d, required 1", err_total - e0); end
    checks++; if (done_total - d0 !== 0) begin errors++; $display("FAIL nack_done_pulses: got %0d, required 0", done_total - d0); end
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin errors++; $display("FAIL nack_release: clk_oe=%b data_oe=%b, required 0/0", ps2_clk_oe, ps2_data_oe); end
    checks++; if (busy !== 1'b0 || tx_ready !== 1'b1) begin errors++; $display("FAIL nack_idle: busy=%b ready=%b, required 0/1", busy, tx_ready); end
  endtask

  task automatic test_timeout;
    logic [10:0] cap;
    int d0, w, delta;
    bit got;
    d0 = done_total;
    send_byte(8'h5A);
    device_xfer(1'b1, 5, cap);
    got = 1'b0;
    w = 0;
    while (!got && w < TIMEOUT + 100) begin
      @(negedge clk);
      w++;
      if (tx_err) got = 1'b1;
    end
    delta = cyc - fall_cyc;
    checks++; if (!got) begin errors++; $display("FAIL timeout_err: no tx_err within %0d cycles, required a pulse", w); end
    checks++; if (delta < TIMEOUT - 3 || delta > TIMEOUT + 3) begin errors++; $display("FAIL timeout_latency: got %0d cycles, required %0d +-3", delta, TIMEOUT); end
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin errors++; $display("FAIL timeout_release: clk_oe=%b data_oe=%b, required 0/0", ps2_clk_oe, ps2_data_oe); end
    repeat (3) @(negedge clk);
    dev_clk = 1'b1;
    checks++; if (busy !== 1'b0 || done_total - d0 !== 0) begin errors++; $display("FAIL timeout_idle: busy=%b done_pulses=%0d, required 0/0", busy, done_total - d0); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [10:0] cap;
    int d0, e0;
    send_byte(8'hF0);
    device_xfer(1'b1, 3, cap);
    repeat (5) @(negedge clk);
    dev_clk = 1'b1;
    repeat (20) @(negedge clk);
    d0 = done_total; e0 = err_total;
    #2;
    checks++; if (ps2_data_oe !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL midrst_pre: data_oe=%b busy=%b, required 1/1", ps2_data_oe, busy); end
    rst = 1'b0;
    #1;
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin errors++; $display("FAIL midrst_release: clk_oe=%b data_oe=%b, required 0/0", ps2_clk_oe, ps2_data_oe); end
    checks++; if (busy !== 1'b0 || tx_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle: busy=%b ready=%b, required 0/1", busy, tx_ready); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (done_total != d0 || err_total != e0) begin errors++; $display("FAIL midrst_pulses: done=%0d err=%0d, required 0/0", done_total - d0, err_total - e0); end
    d0 = done_total;
    send_byte(8'h00);
    device_xfer(1'b1, 11, cap);
    checks++; if (cap !== {1'b1, 1'b1, 8'h00, 1'b0}) begin errors++; $display("FAIL midrst_fresh_frame: got %b, required %b", cap, {1'b1, 1'b1, 8'h00, 1'b0}); end
    checks++; if (done_total - d0 !== 1) begin errors++; $display("FAIL midrst_fresh_done: got %0d, required 1", done_total - d0); end
  endtask

  task automatic test_pulse_rules;
    checks++; if (accept_pulse_bad !== 1'b0) begin errors++; $display("FAIL pulse_in_accept: got 1, required 0"); end
    checks++; if (both_pulse_bad !== 1'b0)   begin errors++; $display("FAIL done_and_err_together: got 1, required 0"); end
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_parity();
    test_back_to_back();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_pulse_rules();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
